// File: rtl/aes_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_pkg: AES-256 constants, FSM/round-key types and byte helpers.  Rev 1.0
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int NR      = 14;
    localparam int BLOCK_W = 128;
    localparam int KEY_W   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [BLOCK_W-1:0] rk_t [NR:0];

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < n; j++) begin
            r = xtime(r);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_encrypt_ctrl_round.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_round: one combinational AES round; MixColumns skipped when last=1.  Rev 1.0
// ----------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               last,
    output logic [BLOCK_W-1:0] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb[i] = sub_byte(state_in[BLOCK_W-1-8*i -: 8]);
        end
    end

    // Byte index is row + 4*column; row r rotates left by r columns.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                      ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                      ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2]
                      ^ xtime(sr[4*c+3]);
        end
    end

    always_comb begin
        state_out = '0;
        for (int i = 0; i < 16; i++) begin
            state_out[BLOCK_W-1-8*i -: 8] = (last ? sr[i] : mc[i])
                                          ^ round_key[BLOCK_W-1-8*i -: 8];
        end
    end

endmodule

`default_nettype wire

// File: rtl/expand_key.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ExpandKey: combinational AES-256 key schedule, 15 round keys.  Rev 1.0
// ----------------------------------------------------------------------------
module ExpandKey
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0] key_in,
    output rk_t              key_out
);

    always_comb begin : b_expand
        logic [31:0] w [4*(NR+1)];
        logic [31:0] temp;
        for (int i = 0; i < 8; i++) begin
            w[i] = key_in[KEY_W-1-32*i -: 32];
        end
        for (int i = 8; i < 4*(NR+1); i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rcon(i/8), 24'h000000};
            end else if (i % 8 == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int r = 0; r <= NR; r++) begin
            key_out[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/aes_encrypt_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_encrypt_ctrl: iterative AES-256 encryptor, one round per clock.  Rev 1.0
// ----------------------------------------------------------------------------
module aes_encrypt_ctrl
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [KEY_W-1:0]   in_key,
    input  logic               in_new_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    state_t             state;
    state_t             state_next;
    logic [3:0]         round;
    logic [KEY_W-1:0]   key_reg;
    logic [BLOCK_W-1:0] state_reg;
    rk_t                key_out;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;
    logic [BLOCK_W-1:0] rk0;
    logic               accept;
    logic               last_round;

    ExpandKey u_expand (
        .key_in  (key_reg),
        .key_out (key_out)
    );

    always_comb begin
        round_key = key_out[0];
        for (int r = 1; r <= NR; r++) begin
            if (round == 4'(r)) begin
                round_key = key_out[r];
            end
        end
    end

    assign last_round = (round == 4'(NR));

    aes_round u_round (
        .state_in  (state_reg),
        .round_key (round_key),
        .last      (last_round),
        .state_out (round_out)
    );

    // Round 0 key comes straight from the request so accept needs no extra cycle.
    assign rk0      = in_new_key ? in_key[KEY_W-1 -: BLOCK_W] : key_reg[KEY_W-1 -: BLOCK_W];
    assign accept   = in_valid && in_ready;
    assign out_data = state_reg;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = in_valid ? ROUND : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round     <= 4'd0;
            key_reg   <= '0;
            state_reg <= '0;
        end else if (accept) begin
            if (in_new_key) begin
                key_reg <= in_key;
            end
            state_reg <= in_data ^ rk0;
            round     <= 4'd1;
        end else if (state == ROUND) begin
            state_reg <= round_out;
            if (!last_round) begin
                round <= round + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire
